// File: rtl/screen_arb_pkg.sv
// Shared types and sizing for the screen RAM arbiter.
package screen_arb_pkg;

    localparam int SCREEN_WORDS = 8192;
    localparam int DEF_ADDR_W   = 13;
    localparam int DEF_DATA_W   = 16;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        WRITE        = 2'd1,
        READ_WAIT    = 2'd2,
        READ_CAPTURE = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWN_VGA = 1'b0,
        OWN_CPU = 1'b1
    } owner_e;

endpackage

// File: rtl/screen_ram_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int WIDTH = 4,
    parameter int LIMIT = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] count_o
);
    localparam logic [WIDTH-1:0] LIMIT_V = WIDTH'(LIMIT);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q < LIMIT_V)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/screen_ram_arbiter.sv
// Shares the single-port screen RAM between the VGA word fetch and the CPU port.
// Define SCREEN_ARB_PERF_EN to add the conflict_count performance counter.
module screen_ram_arbiter
    import screen_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic [DATA_W-1:0] vga_data,
    output logic              vga_valid,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
`ifdef SCREEN_ARB_PERF_EN
    ,
    output logic [15:0]       conflict_count
`endif
);
    localparam int STARVE_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    arb_state_e        state_q, state_d;
    owner_e            owner_q, owner_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic              ram_we_q, ram_we_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic [DATA_W-1:0] vga_data_q, vga_data_d;
    logic              vga_valid_q, vga_valid_d;
    logic [ADDR_W-1:0] vga_held_q, vga_held_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;

    logic [STARVE_W-1:0] starve_cnt;
    logic vga_pending, starve_hit, grant_vga, grant_cpu;

    assign vga_pending = !vga_valid_q || (vga_addr != vga_held_q);
    assign starve_hit  = (starve_cnt >= STARVE_MAX);
    assign grant_vga   = (state_q == IDLE) && vga_pending && !(cpu_req && starve_hit);
    assign grant_cpu   = (state_q == IDLE) && cpu_req && !grant_vga;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        ram_addr_d  = ram_addr_q;
        ram_we_d    = 1'b0;
        ram_wdata_d = ram_wdata_q;
        vga_data_d  = vga_data_q;
        vga_valid_d = vga_valid_q;
        vga_held_d  = vga_held_q;
        cpu_ack_d   = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        unique case (state_q)
            IDLE: begin
                if (grant_cpu) begin
                    owner_d    = OWN_CPU;
                    ram_addr_d = cpu_addr;
                    if (cpu_we) begin
                        ram_we_d    = 1'b1;
                        ram_wdata_d = cpu_wdata;
                        state_d     = WRITE;
                    end else begin
                        state_d = READ_WAIT;
                    end
                end else if (grant_vga) begin
                    owner_d    = OWN_VGA;
                    ram_addr_d = vga_addr;
                    state_d    = READ_WAIT;
                end
            end
            WRITE: begin
                cpu_ack_d = 1'b1;
                state_d   = IDLE;
                // Keep the held word coherent so no refetch is needed after a CPU write.
                if (vga_valid_q && (vga_held_q == ram_addr_q)) begin
                    vga_data_d = ram_wdata_q;
                end
            end
            READ_WAIT: begin
                state_d = READ_CAPTURE;
            end
            READ_CAPTURE: begin
                state_d = IDLE;
                if (owner_q == OWN_VGA) begin
                    vga_data_d  = ram_rdata;
                    vga_held_d  = ram_addr_q;
                    vga_valid_d = 1'b1;
                end else begin
                    cpu_rdata_d = ram_rdata;
                    cpu_ack_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            owner_q     <= OWN_VGA;
            ram_addr_q  <= '0;
            ram_we_q    <= 1'b0;
            ram_wdata_q <= '0;
            vga_data_q  <= '0;
            vga_valid_q <= 1'b0;
            vga_held_q  <= '0;
            cpu_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            ram_addr_q  <= ram_addr_d;
            ram_we_q    <= ram_we_d;
            ram_wdata_q <= ram_wdata_d;
            vga_data_q  <= vga_data_d;
            vga_valid_q <= vga_valid_d;
            vga_held_q  <= vga_held_d;
            cpu_ack_q   <= cpu_ack_d;
            cpu_rdata_q <= cpu_rdata_d;
        end
    end

    // A waiting CPU request counts each loss to VGA; any CPU grant clears it.
    sat_counter #(
        .WIDTH (STARVE_W),
        .LIMIT (STARVE_LIMIT)
    ) u_starve_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (grant_vga && cpu_req),
        .clr_i   (grant_cpu),
        .count_o (starve_cnt)
    );

`ifdef SCREEN_ARB_PERF_EN
    sat_counter #(
        .WIDTH (16),
        .LIMIT (16'hFFFF)
    ) u_conflict_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   ((state_q == IDLE) && cpu_req && vga_pending),
        .clr_i   (1'b0),
        .count_o (conflict_count)
    );
`endif

    assign vga_data  = vga_data_q;
    assign vga_valid = vga_valid_q;
    assign cpu_ack   = cpu_ack_q;
    assign cpu_rdata = cpu_rdata_q;
    assign ram_addr  = ram_addr_q;
    assign ram_we    = ram_we_q;
    assign ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_screen_ram_arbiter.sv
// Bench for screen_ram_arbiter: directed latency/coherence/starvation/reset cases, then
// randomized CPU+VGA traffic against a word-level memory model.
module tb_screen_ram_arbiter;
    localparam int SL        = 2;
    localparam int CPU_BOUND = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [12:0] vga_addr = '0;
    logic [15:0] vga_data;
    logic        vga_valid;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [12:0] cpu_addr = '0;
    logic [15:0] cpu_wdata = '0;
    logic        cpu_ack;
    logic [15:0] cpu_rdata;
    logic [12:0] ram_addr;
    logic        ram_we;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata;
`ifdef SCREEN_ARB_PERF_EN
    logic [15:0] conflict_count;
`endif

    screen_ram_arbiter #(.STARVE_LIMIT(SL), .ADDR_W(13), .DATA_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .vga_addr  (vga_addr),
        .vga_data  (vga_data),
        .vga_valid (vga_valid),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ack   (cpu_ack),
        .cpu_rdata (cpu_rdata),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
`ifdef SCREEN_ARB_PERF_EN
        ,
        .conflict_count (conflict_count)
`endif
    );

    always #5 clk = ~clk;

    // Single-port RAM with registered read; bd_* is a backdoor port for the bench.
    logic [15:0] mem [0:8191];
    logic        bd_we = 1'b0;
    logic [12:0] bd_addr = '0;
    logic [15:0] bd_data = '0;
    always @(posedge clk) begin
        if (bd_we) mem[bd_addr] <= bd_data;
        else if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    int we_cnt = 0;
    always @(posedge clk) if (ram_we) we_cnt <= we_cnt + 1;

    logic [15:0] ref_mem [0:8191];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bd_write(input logic [12:0] a, input logic [15:0] d);
        bd_we = 1'b1; bd_addr = a; bd_data = d;
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    task automatic cpu_do(input logic we, input logic [12:0] a, input logic [15:0] d,
                          input int lat, input string tag);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
        for (int i = 1; i <= lat; i++) begin
            @(negedge clk);
            if (i < lat) chk({tag, "_early_ack"}, cpu_ack, 1'b0);
            else         chk({tag, "_ack"}, cpu_ack, 1'b1);
        end
        if (!we) chk({tag, "_rdata"}, cpu_rdata, ref_mem[a]);
        else     ref_mem[a] = d;
        cpu_req = 1'b0;
    endtask

    task automatic vga_set(input logic [12:0] a, input string tag);
        vga_addr = a;
        tick(12);
        chk({tag, "_valid"}, vga_valid, 1'b1);
        chk({tag, "_data"}, vga_data, ref_mem[a]);
    endtask

    // CPU read of 0x1FFF held while VGA keeps moving: VGA may win SL times, then CPU.
    task automatic starve_round(input logic [12:0] a1, input logic [12:0] a2,
                                input logic [12:0] a3, input string tag);
`ifdef SCREEN_ARB_PERF_EN
        logic [15:0] cc0;
        cc0 = conflict_count;
`endif
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h1FFF;
        vga_addr = a1;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            if (i == 3) begin
                chk({tag, "_vga1"}, vga_data, ref_mem[a1]);
                vga_addr = a2;
            end
            if (i == 6) begin
                chk({tag, "_vga2"}, vga_data, ref_mem[a2]);
                vga_addr = a3;
            end
            if (i < 9) chk({tag, "_early_ack"}, cpu_ack, 1'b0);
        end
        chk({tag, "_ack"}, cpu_ack, 1'b1);
        chk({tag, "_rdata"}, cpu_rdata, ref_mem[13'h1FFF]);
        cpu_req = 1'b0;
        tick(6);
        chk({tag, "_vga3"}, vga_data, ref_mem[a3]);
`ifdef SCREEN_ARB_PERF_EN
        chk({tag, "_conflicts"}, conflict_count - cc0, 16'd3);
`endif
    endtask

    function automatic logic [12:0] pick_addr();
        case ($urandom_range(0, 9))
            0:       return 13'h1FFF;
            1:       return 13'h0010;
            default: return 13'h0100 + 13'($urandom_range(0, 15));
        endcase
    endfunction

    logic [12:0] used [0:19];
    bit          busy;
    int          gap, wt, hold, ack_seen;
    logic        we_r;
    logic [12:0] a_r;
    logic [15:0] d_r;
    int          we0;

    initial begin
        for (int i = 0; i < 16; i++) used[i] = 13'h0100 + 13'(i);
        used[16] = 13'h0000; used[17] = 13'h0010; used[18] = 13'h0020; used[19] = 13'h0030;
        @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            ref_mem[used[i]] = 16'($urandom);
            bd_write(used[i], ref_mem[used[i]]);
        end
        ref_mem[13'h0000] = 16'h0F0F; bd_write(13'h0000, 16'h0F0F);
        ref_mem[13'h0010] = 16'hA5A5; bd_write(13'h0010, 16'hA5A5);
        ref_mem[13'h1FFF] = 16'h0000; bd_write(13'h1FFF, 16'h0000);

        chk("rst_vga_valid", vga_valid, 1'b0);
        chk("rst_vga_data", vga_data, 16'h0);
        chk("rst_cpu_ack", cpu_ack, 1'b0);
        chk("rst_cpu_rdata", cpu_rdata, 16'h0);
        chk("rst_ram_we", ram_we, 1'b0);
        chk("rst_ram_addr", ram_addr, 13'h0);
        chk("rst_ram_wdata", ram_wdata, 16'h0);

        rst_n = 1'b1;
        tick(6);
        chk("boot_vga_valid", vga_valid, 1'b1);
        chk("boot_vga_data", vga_data, ref_mem[13'h0000]);

        we0 = we_cnt;
        vga_addr = 13'h0010;
        tick(2);
        chk("vga_e2_old", vga_data, 16'h0F0F);
        tick(1);
        chk("vga_e3_data", vga_data, 16'hA5A5);
        chk("vga_e3_valid", vga_valid, 1'b1);
        chk("vga_no_we", we_cnt - we0, 0);

        cpu_do(1'b1, 13'h1FFF, 16'h1234, 2, "cpu_wr");
        tick(1);
        chk("cpu_ack_pulse", cpu_ack, 1'b0);
        cpu_do(1'b0, 13'h1FFF, 16'h0, 3, "cpu_rd");
        tick(1);

        vga_set(13'h0100, "coh_setup");
        cpu_do(1'b1, 13'h0100, 16'hBEEF, 2, "coh_wr");
        chk("coh_vga_data", vga_data, 16'hBEEF);
        bd_write(13'h0100, 16'h5555);
        tick(6);
        chk("coh_no_refetch", vga_data, 16'hBEEF);
        bd_write(13'h0100, 16'hBEEF);
        tick(1);

        starve_round(13'h0020, 13'h0030, 13'h0010, "starve1");
        starve_round(13'h0101, 13'h0102, 13'h0103, "starve2");

        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0107; cpu_wdata = 16'h7777;
        @(negedge clk);
        chk("rmw_we_on", ram_we, 1'b1);
        #2 rst_n = 1'b0;
        #1 chk("rmw_we_async", ram_we, 1'b0);
        cpu_req = 1'b0;
        tick(2);
        chk("rmw_rst_ack", cpu_ack, 1'b0);
        chk("rmw_rst_vga_valid", vga_valid, 1'b0);
        rst_n = 1'b1;
        ack_seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (cpu_ack) ack_seen = 1;
        end
        chk("rmw_no_ack", ack_seen, 0);
        chk("rmw_vga_refetch", vga_data, ref_mem[13'h0103]);
        cpu_do(1'b0, 13'h0107, 16'h0, 3, "rmw_rd_idle");
        tick(1);
        cpu_do(1'b1, 13'h0107, 16'h4321, 2, "rmw_wr_idle");
        tick(1);

        busy = 0; gap = 0; wt = 0; hold = 0;
        for (int cyc = 0; cyc < 3200; cyc++) begin
            if (cyc >= 3000 && !busy) break;
            @(negedge clk);
            if (busy) begin
                if (cpu_ack) begin
                    chk("rnd_cpu_lat", wt <= CPU_BOUND, 1'b1);
                    if (!we_r) chk("rnd_cpu_rdata", cpu_rdata, ref_mem[a_r]);
                    else       ref_mem[a_r] = d_r;
                    busy = 0; cpu_req = 1'b0; gap = $urandom_range(0, 3);
                end else begin
                    wt++;
                    if (wt == CPU_BOUND + 1) chk("rnd_cpu_timeout", wt, CPU_BOUND);
                end
            end else begin
                if (cpu_ack) chk("rnd_cpu_spurious_ack", cpu_ack, 1'b0);
                if (gap > 0) gap--;
                else if ($urandom_range(0, 2) != 0 && cyc < 3000) begin
                    we_r = 1'($urandom_range(0, 1));
                    a_r  = ($urandom_range(0, 2) == 0) ? vga_addr : pick_addr();
                    d_r  = 16'($urandom);
                    cpu_req = 1'b1; cpu_we = we_r; cpu_addr = a_r; cpu_wdata = d_r;
                    wt = 0; busy = 1;
                end
            end
            if (hold == 0) begin
                if (cyc > 0) begin
                    chk("rnd_vga_valid", vga_valid, 1'b1);
                    chk("rnd_vga_data", vga_data, ref_mem[vga_addr]);
                end
                vga_addr = pick_addr();
                hold = $urandom_range(12, 20);
            end else begin
                hold--;
            end
        end
        cpu_req = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach its summary in time");
        $fatal(1, "watchdog");
    end

endmodule
